// File: rtl/q_argmax_scan_ctrl_if.sv
// Bus bundle between the Q-value argmax sequencer and its user / 16:1 mux.
// The slave modport is the sequencer side; the master modport is the
// requester that drives start/mask and supplies the mux output.
interface q_argmax_scan_ctrl_if #(
   parameter int unsigned DW = 16
);
   logic          start;
   logic [15:0]   mask;
   logic [DW-1:0] mux_dout;
   logic [3:0]    mux_sel;
   logic          busy;
   logic          done;
   logic [DW-1:0] max_val;
   logic [3:0]    max_idx;
   logic          none_valid;

   modport slave (
      input  start,
      input  mask,
      input  mux_dout,
      output mux_sel,
      output busy,
      output done,
      output max_val,
      output max_idx,
      output none_valid
   );

   modport master (
      output start,
      output mask,
      output mux_dout,
      input  mux_sel,
      input  busy,
      input  done,
      input  max_val,
      input  max_idx,
      input  none_valid
   );
endinterface

// File: rtl/q_argmax_scan_ctrl.sv
// Sequencer for the 16:1 Q-value mux: steps mux_sel across FIRST_IDX..LAST_IDX,
// one index per clock, keeps a running masked maximum (strict '>', so ties go
// to the lowest index) and reports the best value, its index and whether no
// legal candidate was seen.
module q_argmax_scan_ctrl #(
   parameter int unsigned DW        = 16,
   parameter int unsigned FIRST_IDX = 1,
   parameter int unsigned LAST_IDX  = 15,
   parameter bit          SIGNED    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   q_argmax_scan_ctrl_if.slave     bus
);

   localparam logic [3:0] SEL_FIRST = 4'(FIRST_IDX);
   localparam logic [3:0] SEL_LAST  = 4'(LAST_IDX);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [3:0]    sel;
   logic [15:0]   mask_r;
   logic [DW-1:0] best;
   logic [3:0]    best_idx;
   logic          found;
   logic [DW-1:0] max_val_r;
   logic [3:0]    max_idx_r;
   logic          none_r;

   logic          gt;
   logic          take;
   logic [DW-1:0] best_nx;
   logic [3:0]    idx_nx;
   logic          found_nx;

   // Candidate compare: current mux output against the running best.
   always_comb begin
      gt = 1'b0;
      if (SIGNED) begin
         gt = $signed(bus.mux_dout) > $signed(best);
      end else begin
         gt = bus.mux_dout > best;
      end
      take     = mask_r[sel] && (!found || gt);
      best_nx  = take ? bus.mux_dout : best;
      idx_nx   = take ? sel : best_idx;
      found_nx = found | take;
   end

   // Scan FSM and result registers. Results are loaded on the final SCAN edge
   // (using the last sample's outcome) so they are already valid while done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         sel       <= SEL_FIRST;
         mask_r    <= '0;
         best      <= '0;
         best_idx  <= '0;
         found     <= 1'b0;
         max_val_r <= '0;
         max_idx_r <= '0;
         none_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               sel <= SEL_FIRST;
               if (bus.start) begin
                  mask_r   <= bus.mask;
                  found    <= 1'b0;
                  best     <= '0;
                  best_idx <= '0;
                  state    <= S_SCAN;
               end
            end
            S_SCAN: begin
               best     <= best_nx;
               best_idx <= idx_nx;
               found    <= found_nx;
               if (sel == SEL_LAST) begin
                  state     <= S_DONE;
                  max_val_r <= found_nx ? best_nx : '0;
                  max_idx_r <= found_nx ? idx_nx : '0;
                  none_r    <= ~found_nx;
               end else begin
                  sel <= sel + 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               sel   <= SEL_FIRST;
            end
            default: begin
               state <= S_IDLE;
               sel   <= SEL_FIRST;
            end
         endcase
      end
   end

   assign bus.mux_sel    = sel;
   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = (state == S_DONE);
   assign bus.max_val    = max_val_r;
   assign bus.max_idx    = max_idx_r;
   assign bus.none_valid = none_r;

endmodule
